// File: rtl/sys_ctrl_gen.sv
// ---------------------------------------------------------------------------
// sys_ctrl_gen
//   Command-frame controller between the UART RX byte stream and the register
//   file / ALU / TX FIFO. Decodes RF write (AA), RF read (BB), ALU op with
//   operands (CC) and ALU op without operands (DD). Results are buffered and
//   pushed LSB byte first into the TX FIFO under FIFO_FULL backpressure.
//
//   Optional build macro: SYS_CTRL_ERR_RESP_EN
//     defined   - every frame_err also sends a one-byte 8'hEE response
//     undefined - aborts only pulse frame_err
//
// Ports
//   CLK, RST (async, active-low)
//   RX_P_DATA, RX_D_VLD, parity_error, Framing_error : RX byte stream
//   RdData, RdData_Valid                             : RF read return
//   ALU_OUT, OUT_Valid                               : ALU result return
//   FIFO_FULL                                        : TX FIFO full flag
//   ALU_FUN, ALU_EN, CLK_EN                          : ALU control (registered)
//   Address, WrEn, RdEn, WrData                      : RF control (registered)
//   TX_P_DATA (registered), TX_D_VLD                 : TX FIFO push
//   clk_div_en (constant 1), busy, frame_err
// ---------------------------------------------------------------------------
// state    | meaning
// IDLE     | waiting for an opcode byte
// WR_ADDR  | RF write: waiting for address byte
// WR_DATA  | RF write: waiting for data byte
// RD_ADDR  | RF read: waiting for address byte
// RD_WAIT  | RF read: waiting for RdData_Valid
// OPA      | ALU op: waiting for operand A (written to RF addr 0)
// OPB      | ALU op: waiting for operand B (written to RF addr 1)
// FUN      | ALU op: waiting for function byte
// ALU_WAIT | ALU enabled, waiting for OUT_Valid
// TX_SEND  | pushing buffered result bytes to the TX FIFO
// ---------------------------------------------------------------------------
module sys_ctrl_gen #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int ALU_OUT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic                     parity_error,
  input  logic                     Framing_error,
  input  logic [DATA_WIDTH-1:0]    RdData,
  input  logic                     RdData_Valid,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     OUT_Valid,
  input  logic                     FIFO_FULL,
  output logic [FUN_WIDTH-1:0]     ALU_FUN,
  output logic                     ALU_EN,
  output logic                     CLK_EN,
  output logic [ADDR_WIDTH-1:0]    Address,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [DATA_WIDTH-1:0]    WrData,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD,
  output logic                     clk_div_en,
  output logic                     busy,
  output logic                     frame_err
);

  localparam int NB    = ALU_OUT_WIDTH / DATA_WIDTH;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TMO_W-1:0] TMO_MAX      = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST_ALU = IDX_W'(NB - 1);

  localparam logic [7:0] OP_WR  = 8'hAA;
  localparam logic [7:0] OP_RD  = 8'hBB;
  localparam logic [7:0] OP_ALU = 8'hCC;
  localparam logic [7:0] OP_NOP = 8'hDD;

`ifdef SYS_CTRL_ERR_RESP_EN
  localparam logic [DATA_WIDTH-1:0] ERR_BYTE = DATA_WIDTH'(8'hEE);
`endif

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX_SEND
  } state_t;

  state_t                   state;
  logic [ALU_OUT_WIDTH-1:0] res_buf;
  logic [ALU_OUT_WIDTH-1:0] res_buf_shr;
  logic [IDX_W-1:0]         idx;
  logic [IDX_W-1:0]         last_idx;
  logic [TMO_W-1:0]         tmo_cnt;

  logic good_byte, bad_byte, op_known;
  logic collecting, tmo_state, tmo_hit, resp_wins, abort, tx_push;

  assign good_byte  = RX_D_VLD & ~(parity_error | Framing_error);
  assign bad_byte   = RX_D_VLD &  (parity_error | Framing_error);
  assign op_known   = (RX_P_DATA[7:0] == OP_WR)  || (RX_P_DATA[7:0] == OP_RD) ||
                      (RX_P_DATA[7:0] == OP_ALU) || (RX_P_DATA[7:0] == OP_NOP);
  assign tmo_hit    = (tmo_cnt == TMO_MAX);
  assign resp_wins  = ((state == RD_WAIT)  && RdData_Valid) ||
                      ((state == ALU_WAIT) && OUT_Valid);
  assign tx_push    = (state == TX_SEND) && !FIFO_FULL;
  // Buffer is a shift register: the next byte to send is always the low byte.
  assign res_buf_shr = res_buf >> DATA_WIDTH;

  assign TX_D_VLD   = tx_push;
  assign busy       = (state != IDLE);
  assign clk_div_en = 1'b1;

  always_comb begin
    collecting = 1'b0;
    tmo_state  = 1'b0;
    case (state)
      WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN: begin
        collecting = 1'b1;
        tmo_state  = 1'b1;
      end
      RD_WAIT, ALU_WAIT: tmo_state = 1'b1;
      default: ;
    endcase
  end

  // A good byte or a returning response beats a coinciding timeout.
  assign abort = (collecting && bad_byte) ||
                 ((state == IDLE) && good_byte && !op_known) ||
                 (tmo_state && tmo_hit && !good_byte && !resp_wins);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      res_buf   <= '0;
      idx       <= '0;
      last_idx  <= '0;
      tmo_cnt   <= '0;
      ALU_FUN   <= '0;
      ALU_EN    <= 1'b0;
      CLK_EN    <= 1'b0;
      Address   <= '0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      WrData    <= '0;
      TX_P_DATA <= '0;
      frame_err <= 1'b0;
    end else begin
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      frame_err <= 1'b0;

      if (good_byte || !tmo_state)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (abort) begin
        frame_err <= 1'b1;
        ALU_EN    <= 1'b0;
        CLK_EN    <= 1'b0;
        tmo_cnt   <= '0;
`ifdef SYS_CTRL_ERR_RESP_EN
        res_buf   <= ALU_OUT_WIDTH'(ERR_BYTE);
        TX_P_DATA <= ERR_BYTE;
        idx       <= '0;
        last_idx  <= '0;
        state     <= TX_SEND;
`else
        state     <= IDLE;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (good_byte) begin
              case (RX_P_DATA[7:0])
                OP_WR:   state <= WR_ADDR;
                OP_RD:   state <= RD_ADDR;
                OP_ALU:  state <= OPA;
                OP_NOP:  state <= FUN;
                default: state <= IDLE;
              endcase
            end
          end
          WR_ADDR: begin
            if (good_byte) begin
              Address <= RX_P_DATA[ADDR_WIDTH-1:0];
              state   <= WR_DATA;
            end
          end
          WR_DATA: begin
            if (good_byte) begin
              WrEn   <= 1'b1;
              WrData <= RX_P_DATA;
              state  <= IDLE;
            end
          end
          RD_ADDR: begin
            if (good_byte) begin
              RdEn    <= 1'b1;
              Address <= RX_P_DATA[ADDR_WIDTH-1:0];
              state   <= RD_WAIT;
            end
          end
          RD_WAIT: begin
            if (RdData_Valid) begin
              res_buf   <= ALU_OUT_WIDTH'(RdData);
              TX_P_DATA <= RdData;
              idx       <= '0;
              last_idx  <= '0;
              tmo_cnt   <= '0;
              state     <= TX_SEND;
            end
          end
          OPA: begin
            if (good_byte) begin
              WrEn    <= 1'b1;
              Address <= '0;
              WrData  <= RX_P_DATA;
              state   <= OPB;
            end
          end
          OPB: begin
            if (good_byte) begin
              WrEn    <= 1'b1;
              Address <= ADDR_WIDTH'(1);
              WrData  <= RX_P_DATA;
              state   <= FUN;
            end
          end
          FUN: begin
            if (good_byte) begin
              ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0];
              ALU_EN  <= 1'b1;
              CLK_EN  <= 1'b1;
              state   <= ALU_WAIT;
            end
          end
          ALU_WAIT: begin
            // CLK_EN stays on through TX_SEND so the ALU result stays stable.
            if (OUT_Valid) begin
              ALU_EN    <= 1'b0;
              res_buf   <= ALU_OUT;
              TX_P_DATA <= ALU_OUT[DATA_WIDTH-1:0];
              idx       <= '0;
              last_idx  <= IDX_LAST_ALU;
              tmo_cnt   <= '0;
              state     <= TX_SEND;
            end
          end
          TX_SEND: begin
            if (tx_push) begin
              if (idx == last_idx) begin
                idx    <= '0;
                CLK_EN <= 1'b0;
                state  <= IDLE;
              end else begin
                idx       <= idx + IDX_W'(1);
                res_buf   <= res_buf_shr;
                TX_P_DATA <= res_buf_shr[DATA_WIDTH-1:0];
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sys_ctrl_gen.sv
module tb_sys_ctrl_gen;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int FW  = 4;
  localparam int OW  = 16;
  localparam int TMO = 40;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] RX_P_DATA;
  logic          RX_D_VLD;
  logic          parity_error;
  logic          Framing_error;
  logic [DW-1:0] RdData;
  logic          RdData_Valid;
  logic [OW-1:0] ALU_OUT;
  logic          OUT_Valid;
  logic          FIFO_FULL;
  logic [FW-1:0] ALU_FUN;
  logic          ALU_EN;
  logic          CLK_EN;
  logic [AW-1:0] Address;
  logic          WrEn;
  logic          RdEn;
  logic [DW-1:0] WrData;
  logic [DW-1:0] TX_P_DATA;
  logic          TX_D_VLD;
  logic          clk_div_en;
  logic          busy;
  logic          frame_err;

  sys_ctrl_gen #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW),
    .ALU_OUT_WIDTH(OW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .parity_error(parity_error), .Framing_error(Framing_error),
    .RdData(RdData), .RdData_Valid(RdData_Valid),
    .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid), .FIFO_FULL(FIFO_FULL),
    .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .CLK_EN(CLK_EN),
    .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .clk_div_en(clk_div_en), .busy(busy), .frame_err(frame_err)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: expectations pushed when stimulus is driven, popped by the monitor.
  logic [AW+DW-1:0] exp_wr[$];
  logic [AW-1:0]    exp_rd[$];
  logic [DW-1:0]    exp_tx[$];
  int               exp_err = 0;
  bit               mon_en  = 1'b0;

  always @(negedge CLK) begin
    logic [AW+DW-1:0] ew;
    logic [AW-1:0]    er;
    logic [DW-1:0]    et;
    if (mon_en) begin
      if (WrEn) begin
        checks++;
        if (exp_wr.size() == 0) begin
          failures++;
          $display("FAIL wr_strobe: unexpected WrEn addr=%0h data=%0h, required none", Address, WrData);
        end else begin
          ew = exp_wr.pop_front();
          if ({Address, WrData} !== ew) begin
            failures++;
            $display("FAIL wr_strobe: got addr=%0h data=%0h, required addr=%0h data=%0h",
                     Address, WrData, ew[AW+DW-1:DW], ew[DW-1:0]);
          end
        end
      end
      if (RdEn) begin
        checks++;
        if (exp_rd.size() == 0) begin
          failures++;
          $display("FAIL rd_strobe: unexpected RdEn addr=%0h, required none", Address);
        end else begin
          er = exp_rd.pop_front();
          if (Address !== er) begin
            failures++;
            $display("FAIL rd_strobe: got addr=%0h, required %0h", Address, er);
          end
        end
      end
      if (TX_D_VLD) begin
        checks++;
        if (FIFO_FULL) begin
          failures++;
          $display("FAIL tx_push: push while FIFO_FULL, data=%0h", TX_P_DATA);
        end else if (exp_tx.size() == 0) begin
          failures++;
          $display("FAIL tx_push: unexpected push data=%0h, required none", TX_P_DATA);
        end else begin
          et = exp_tx.pop_front();
          if (TX_P_DATA !== et) begin
            failures++;
            $display("FAIL tx_push: got %0h, required %0h", TX_P_DATA, et);
          end
        end
      end
      if (frame_err) begin
        checks++;
        if (exp_err == 0) begin
          failures++;
          $display("FAIL frame_err: unexpected pulse, required none");
        end else begin
          exp_err--;
        end
      end
    end
  end

  task automatic expect_err();
    exp_err++;
`ifdef SYS_CTRL_ERR_RESP_EN
    exp_tx.push_back(8'hEE);
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input logic pe = 1'b0, input logic fe = 1'b0);
    @(posedge CLK); #1;
    RX_P_DATA = b; RX_D_VLD = 1'b1; parity_error = pe; Framing_error = fe;
    @(posedge CLK); #1;
    RX_D_VLD = 1'b0; parity_error = 1'b0; Framing_error = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge CLK);
    while (busy && n < 300) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle: busy=%0b after %0d cycles, required 0", nm, busy, n);
    end
  endtask

  task automatic check_drained(input string nm);
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (exp_wr.size() != 0 || exp_rd.size() != 0 || exp_tx.size() != 0 || exp_err != 0) begin
      failures++;
      $display("FAIL %s_drain: pending wr=%0d rd=%0d tx=%0d err=%0d, required all 0",
               nm, exp_wr.size(), exp_rd.size(), exp_tx.size(), exp_err);
    end
    exp_wr.delete(); exp_rd.delete(); exp_tx.delete(); exp_err = 0;
  endtask

  task automatic wait_alu_en(input string nm);
    int n = 0;
    while (ALU_EN !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (ALU_EN !== 1'b1) begin
      failures++;
      $display("FAIL %s_alu_en: ALU_EN=%0b, required 1", nm, ALU_EN);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    RX_P_DATA = '0; RX_D_VLD = 0; parity_error = 0; Framing_error = 0;
    RdData = '0; RdData_Valid = 0; ALU_OUT = '0; OUT_Valid = 0; FIFO_FULL = 0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({ALU_FUN, ALU_EN, CLK_EN, Address, WrEn, RdEn, WrData, TX_P_DATA, TX_D_VLD, busy, frame_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got fun=%0h alu_en=%0b clk_en=%0b addr=%0h wr=%0b rd=%0b wd=%0h tx=%0h txv=%0b busy=%0b ferr=%0b, required all 0",
               ALU_FUN, ALU_EN, CLK_EN, Address, WrEn, RdEn, WrData, TX_P_DATA, TX_D_VLD, busy, frame_err);
    end
    checks++;
    if (clk_div_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_clk_div_en: got %0b, required 1", clk_div_en);
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'hAA);
    send_byte(8'h05);
    @(negedge CLK);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midreset_busy: got %0b, required 1", busy);
    end
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state: busy=%0b, required 0", busy);
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    // The data byte now lands in IDLE as an unknown opcode.
    expect_err();
    send_byte(8'h3C);
    wait_idle("midreset");
    check_drained("midreset");
  endtask

  task automatic test_write();
    exp_wr.push_back({4'h5, 8'h3C});
    send_byte(8'hAA);
    send_byte(8'h05);
    send_byte(8'h3C);
    wait_idle("write");
    check_drained("write");
  endtask

  task automatic test_read();
    int n = 0;
    exp_rd.push_back(4'h7);
    exp_tx.push_back(8'h5A);
    send_byte(8'hBB);
    send_byte(8'h07);
    while (RdEn !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (RdEn !== 1'b1) begin
      failures++;
      $display("FAIL read_rden: RdEn=%0b, required 1", RdEn);
    end
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL read_wait_busy: got %0b, required 1", busy);
    end
    RdData = 8'h5A; RdData_Valid = 1'b1;
    @(posedge CLK); #1;
    RdData_Valid = 1'b0;
    wait_idle("read");
    check_drained("read");
  endtask

  task automatic test_alu(input bit bp);
    bit pushed = 0, not_busy = 0, en_bad = 0;
    exp_wr.push_back({4'h0, 8'h0A});
    exp_wr.push_back({4'h1, 8'h03});
    exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h12);
    send_byte(8'hCC);
    send_byte(8'h0A);
    send_byte(8'h03);
    send_byte(8'h02);
    wait_alu_en(bp ? "alu_bp" : "alu");
    checks++;
    if (ALU_FUN !== 4'h2 || CLK_EN !== 1'b1) begin
      failures++;
      $display("FAIL alu_fun: got fun=%0h clk_en=%0b, required fun=2 clk_en=1", ALU_FUN, CLK_EN);
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (ALU_EN !== 1'b1 || ALU_FUN !== 4'h2) begin
      failures++;
      $display("FAIL alu_hold: got en=%0b fun=%0h, required en=1 fun=2", ALU_EN, ALU_FUN);
    end
    @(posedge CLK); #1;
    if (bp) FIFO_FULL = 1'b1;
    ALU_OUT = 16'h1234; OUT_Valid = 1'b1;
    @(posedge CLK); #1;
    OUT_Valid = 1'b0;
    if (bp) begin
      repeat (20) begin
        @(negedge CLK);
        if (TX_D_VLD) pushed = 1;
        if (!busy) not_busy = 1;
        if (ALU_EN !== 1'b0 || CLK_EN !== 1'b1) en_bad = 1;
      end
      checks++;
      if (pushed || not_busy) begin
        failures++;
        $display("FAIL bp_stall: pushed=%0b left_busy=%0b, required 0 0", pushed, not_busy);
      end
      checks++;
      if (en_bad) begin
        failures++;
        $display("FAIL bp_enables: ALU_EN/CLK_EN wrong during stall (now %0b/%0b), required 0/1", ALU_EN, CLK_EN);
      end
      @(posedge CLK); #1;
      FIFO_FULL = 1'b0;
    end
    wait_idle(bp ? "alu_bp" : "alu");
    checks++;
    if (CLK_EN !== 1'b0 || ALU_EN !== 1'b0) begin
      failures++;
      $display("FAIL alu_end_enables: got alu_en=%0b clk_en=%0b, required 0 0", ALU_EN, CLK_EN);
    end
    check_drained(bp ? "alu_bp" : "alu");
  endtask

  task automatic test_back_to_back();
    exp_tx.push_back(8'hCD);
    exp_tx.push_back(8'hAB);
    send_byte(8'hDD);
    send_byte(8'h05);
    wait_alu_en("nop");
    checks++;
    if (ALU_FUN !== 4'h5) begin
      failures++;
      $display("FAIL nop_fun: got %0h, required 5", ALU_FUN);
    end
    @(posedge CLK); #1;
    ALU_OUT = 16'hABCD; OUT_Valid = 1'b1;
    @(posedge CLK); #1;
    OUT_Valid = 1'b0;
    wait_idle("nop");
    // Write frame immediately after.
    exp_wr.push_back({4'hE, 8'h99});
    send_byte(8'hAA);
    send_byte(8'h0E);
    send_byte(8'h99);
    wait_idle("b2b_write");
    check_drained("b2b");
  endtask

  task automatic test_errors();
    // Parity error on the address byte of a write frame.
    expect_err();
    send_byte(8'hAA);
    send_byte(8'h05, 1'b1, 1'b0);
    wait_idle("err_parity");
    check_drained("err_parity");
    // Unknown opcode.
    expect_err();
    send_byte(8'h11);
    wait_idle("err_opcode");
    check_drained("err_opcode");
    // Framing error on the function byte of an ALU frame: operands already written.
    exp_wr.push_back({4'h0, 8'h01});
    exp_wr.push_back({4'h1, 8'h02});
    expect_err();
    send_byte(8'hCC);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03, 1'b0, 1'b1);
    wait_idle("err_framing");
    checks++;
    if (ALU_EN !== 1'b0) begin
      failures++;
      $display("FAIL err_framing_alu_en: got %0b, required 0", ALU_EN);
    end
    check_drained("err_framing");
    // Bad byte in IDLE is ignored.
    send_byte(8'hAA, 1'b1, 1'b0);
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL err_idle_bad_byte: busy=%0b, required 0", busy);
    end
    check_drained("err_idle");
  endtask

  task automatic test_timeout();
    int n = 0;
    expect_err();
    send_byte(8'hAA);
    while (frame_err !== 1'b1 && n < 2 * TMO) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (frame_err !== 1'b1 || n < TMO || n > TMO + 3) begin
      failures++;
      $display("FAIL timeout_pulse: frame_err=%0b after %0d cycles, required 1 within %0d..%0d",
               frame_err, n, TMO, TMO + 3);
    end
    wait_idle("timeout");
    check_drained("timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_write();
    test_read();
    test_alu(1'b0);
    test_alu(1'b1);
    test_back_to_back();
    test_errors();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
